sign_extension: RTL and testbench

SIGN_EXTENSION -- requirements
Module: sign_extension

---
 rtl/sign_extension_pkg.sv | 11 +
 rtl/sign_extension_sext_core.sv | 25 ++
 rtl/sign_extension.sv | 50 +++++
 tb/tb_sign_extension.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sign_extension_pkg.sv
// Shared widths for the immediate sign-extension block and its consumers.
// REG_WIDTH is the datapath register width that consumers size against.
package sign_extension_pkg;

    localparam int IN_WIDTH_DEF  = 16;
    localparam int OUT_WIDTH_DEF = 32;
    localparam int REG_WIDTH     = OUT_WIDTH_DEF;

    typedef logic [REG_WIDTH-1:0] reg_word_t;

endpackage : sign_extension_pkg

// File: rtl/sign_extension_sext_core.sv
// Purely combinational extender: produces the sign-extended and the
// zero-extended forms of the immediate.
module sext_core
    import sign_extension_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic [IN_WIDTH-1:0]  in_i,
    output logic [OUT_WIDTH-1:0] out_sext_o,
    output logic [OUT_WIDTH-1:0] out_zext_o
);

    // Equal widths need a separate branch: a zero-count replication is illegal.
    generate
        if (OUT_WIDTH > IN_WIDTH) begin : g_extend
            assign out_sext_o = {{(OUT_WIDTH - IN_WIDTH){in_i[IN_WIDTH-1]}}, in_i};
            assign out_zext_o = {{(OUT_WIDTH - IN_WIDTH){1'b0}}, in_i};
        end else begin : g_same
            assign out_sext_o = in_i;
            assign out_zext_o = in_i;
        end
    endgenerate

endmodule : sext_core

// File: rtl/sign_extension.sv
// Immediate sign extender with combinational outputs and a one-cycle
// registered copy of the sign-extended value and the sign flag.
module sign_extension
    import sign_extension_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET,
    input  logic [IN_WIDTH-1:0]  In,
    output logic [OUT_WIDTH-1:0] Out,
    output logic [OUT_WIDTH-1:0] OutZero,
    output logic                 OutNeg,
    output logic [OUT_WIDTH-1:0] OutReg,
    output logic                 OutNegReg
);

    logic [OUT_WIDTH-1:0] out_reg_d, out_reg_q;
    logic                 out_neg_d, out_neg_q;

    sext_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sext_core (
        .in_i       (In),
        .out_sext_o (Out),
        .out_zext_o (OutZero)
    );

    // The combinational path never touches clock or reset.
    assign OutNeg = In[IN_WIDTH-1];

    assign out_reg_d = Out;
    assign out_neg_d = OutNeg;

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            out_reg_q <= '0;
            out_neg_q <= 1'b0;
        end else begin
            out_reg_q <= out_reg_d;
            out_neg_q <= out_neg_d;
        end
    end

    assign OutReg    = out_reg_q;
    assign OutNegReg = out_neg_q;

endmodule : sign_extension

// File: tb/tb_sign_extension.sv
// Directed bench for sign_extension: combinational extension, register
// stage latency, asynchronous reset behaviour and the equal-width case.
module tb_sign_extension;

    logic        clk;
    logic        rst;
    logic [15:0] in_v;
    logic [31:0] out_v, out_zero_v, out_reg_v;
    logic        out_neg_v, out_neg_reg_v;

    logic [15:0] in_eq;
    logic [15:0] out_eq, out_zero_eq, out_reg_eq;
    logic        out_neg_eq, out_neg_reg_eq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    sign_extension #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .I_CLOCK   (clk),
        .I_RESET   (rst),
        .In        (in_v),
        .Out       (out_v),
        .OutZero   (out_zero_v),
        .OutNeg    (out_neg_v),
        .OutReg    (out_reg_v),
        .OutNegReg (out_neg_reg_v)
    );

    sign_extension #(.IN_WIDTH(16), .OUT_WIDTH(16)) dut_eq (
        .I_CLOCK   (clk),
        .I_RESET   (rst),
        .In        (in_eq),
        .Out       (out_eq),
        .OutZero   (out_zero_eq),
        .OutNeg    (out_neg_eq),
        .OutReg    (out_reg_eq),
        .OutNegReg (out_neg_reg_eq)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later
    // or 1 time unit after a rising edge.
    task automatic drive_in(input logic [15:0] v);
        @(negedge clk);
        in_v = v;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] in;
        logic [31:0] sext;
        logic [31:0] zext;
        logic        neg;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] exp_word;

    initial begin
        vecs[0] = '{16'h7FFF, 32'h00007FFF, 32'h00007FFF, 1'b0};
        vecs[1] = '{16'h8000, 32'hFFFF8000, 32'h00008000, 1'b1};
        vecs[2] = '{16'hFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 1'b1};
        vecs[3] = '{16'h0000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[4] = '{16'h1234, 32'h00001234, 32'h00001234, 1'b0};
        vecs[5] = '{16'hA5C3, 32'hFFFFA5C3, 32'h0000A5C3, 1'b1};

        rst   = 1'b1;
        in_v  = 16'h0000;
        in_eq = 16'h0000;
        #1;
        check("reset_outreg", out_reg_v, 32'h0);
        check("reset_outnegreg", {31'b0, out_neg_reg_v}, 32'h0);

        // Combinational path works while reset is held.
        drive_in(16'h8000);
        check("comb_in_reset_out", out_v, 32'hFFFF8000);

        // Reset held across two edges with In=8001.
        drive_in(16'h8001);
        tick();
        tick();
        check("rst_hold_outreg", out_reg_v, 32'h0);
        check("rst_hold_outnegreg", {31'b0, out_neg_reg_v}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_release_outreg", out_reg_v, 32'hFFFF8001);
        check("rst_release_outnegreg", {31'b0, out_neg_reg_v}, 32'h1);

        // Vector table: combinational checks, then the registered copy one edge later.
        foreach (vecs[i]) begin
            drive_in(vecs[i].in);
            check($sformatf("out_%0d", i), out_v, vecs[i].sext);
            check($sformatf("outzero_%0d", i), out_zero_v, vecs[i].zext);
            check($sformatf("outneg_%0d", i), {31'b0, out_neg_v}, {31'b0, vecs[i].neg});
            exp_q.push_back(vecs[i].sext);
            tick();
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty_%0d: got empty expected entry", i);
            end else begin
                exp_word = exp_q.pop_front();
                check($sformatf("outreg_%0d", i), out_reg_v, exp_word);
                check($sformatf("outnegreg_%0d", i), {31'b0, out_neg_reg_v}, {31'b0, exp_word[31]});
            end
        end

        // One-cycle latency across two consecutive edges.
        drive_in(16'h1234);
        tick();
        check("lat_edge_n", out_reg_v, 32'h00001234);
        @(negedge clk);
        in_v = 16'hF000;
        #1;
        check("lat_hold_before_edge", out_reg_v, 32'h00001234);
        tick();
        check("lat_edge_n1", out_reg_v, 32'hFFFFF000);
        check("lat_edge_n1_neg", {31'b0, out_neg_reg_v}, 32'h1);

        // Mid-cycle asynchronous reset.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outreg", out_reg_v, 32'h0);
        check("async_rst_outnegreg", {31'b0, out_neg_reg_v}, 32'h0);
        in_v = 16'h0042;
        #1;
        check("async_rst_out_tracks", out_v, 32'h00000042);
        check("async_rst_outzero_tracks", out_zero_v, 32'h00000042);
        @(negedge clk);
        rst = 1'b0;

        // Equal widths: Out and OutZero both pass In through unchanged.
        @(negedge clk);
        in_eq = 16'h8F01;
        #1;
        check("eq_out", {16'b0, out_eq}, 32'h00008F01);
        check("eq_outzero", {16'b0, out_zero_eq}, 32'h00008F01);
        check("eq_outneg", {31'b0, out_neg_eq}, 32'h1);
        tick();
        check("eq_outreg", {16'b0, out_reg_eq}, 32'h00008F01);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no completion expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule : tb_sign_extension
